// File: rtl/inst_dec.sv
// RV32I decode stage: splits an instruction word into register indices, func3,
// a sign-extended immediate and a format code behind a one-deep valid/ready register.
module inst_dec #(
  parameter int CNT_W = 16,
  parameter int ILL_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       in_inst,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_type,
  output logic [4:0]        out_rs1,
  output logic [4:0]        out_rs2,
  output logic [4:0]        out_rd,
  output logic [2:0]        out_func3,
  output logic [31:0]       out_imm,
  output logic              out_illegal,
  output logic [CNT_W-1:0]  dec_cnt,
  output logic [ILL_W-1:0]  ill_cnt
);

  typedef enum logic [3:0] {
    FMT_ILL = 4'd0,
    FMT_R0  = 4'd1,
    FMT_R20 = 4'd2,
    FMT_I   = 4'd3,
    FMT_L   = 4'd4,
    FMT_S   = 4'd5,
    FMT_B   = 4'd6,
    FMT_U   = 4'd7,
    FMT_J   = 4'd8
  } fmt_e;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_L = 7'b0000011;
  localparam logic [6:0] OP_S = 7'b0100011;
  localparam logic [6:0] OP_B = 7'b1100011;
  localparam logic [6:0] OP_U = 7'b0110111;
  localparam logic [6:0] OP_J = 7'b1101111;

  localparam logic [6:0] F7_ZERO = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  logic [6:0]  w_opcode;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  fmt_e        w_fmt;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [4:0]  w_rd;
  logic [31:0] w_imm;
  logic        w_accept;
  logic        w_is_ill;

  logic              r_valid;
  logic [3:0]        r_type;
  logic [4:0]        r_rs1;
  logic [4:0]        r_rs2;
  logic [4:0]        r_rd;
  logic [2:0]        r_func3;
  logic [31:0]       r_imm;
  logic              r_illegal;
  logic [CNT_W-1:0]  r_dec_cnt;
  logic [ILL_W-1:0]  r_ill_cnt;

  assign w_opcode = in_inst[6:0];
  assign w_f3     = in_inst[14:12];
  assign w_f7     = in_inst[31:25];

  // Format classification, including the reserved func3/func7 combinations.
  always_comb begin
    w_fmt = FMT_ILL;
    unique case (w_opcode)
      OP_R: begin
        if (w_f7 == F7_ZERO)
          w_fmt = FMT_R0;
        else if (w_f7 == F7_ALT && (w_f3 == 3'd0 || w_f3 == 3'd5))
          w_fmt = FMT_R20;
      end
      OP_I: begin
        if (w_f3 == 3'd1) begin
          if (w_f7 == F7_ZERO) w_fmt = FMT_I;
        end else if (w_f3 == 3'd5) begin
          if (w_f7 == F7_ZERO || w_f7 == F7_ALT) w_fmt = FMT_I;
        end else begin
          w_fmt = FMT_I;
        end
      end
      OP_L: begin
        if (!(w_f3 == 3'd3 || w_f3 == 3'd6 || w_f3 == 3'd7)) w_fmt = FMT_L;
      end
      OP_S: begin
        if (w_f3 < 3'd3) w_fmt = FMT_S;
      end
      OP_B: begin
        if (!(w_f3 == 3'd2 || w_f3 == 3'd3)) w_fmt = FMT_B;
      end
      OP_U:    w_fmt = FMT_U;
      OP_J:    w_fmt = FMT_J;
      default: w_fmt = FMT_ILL;
    endcase
  end

  // Field extraction; fields a format does not use read as zero.
  always_comb begin
    w_rs1 = in_inst[19:15];
    w_rs2 = in_inst[24:20];
    w_rd  = in_inst[11:7];
    w_imm = '0;
    unique case (w_fmt)
      FMT_R0, FMT_R20: begin
        w_imm = '0;
      end
      FMT_I, FMT_L: begin
        w_rs2 = '0;
        w_imm = {{20{in_inst[31]}}, in_inst[31:20]};
      end
      FMT_S: begin
        w_rd  = '0;
        w_imm = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      end
      FMT_B: begin
        w_rd  = '0;
        w_imm = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                 in_inst[30:25], in_inst[11:8], 1'b0};
      end
      FMT_U: begin
        w_rs1 = '0;
        w_rs2 = '0;
        w_imm = {in_inst[31:12], 12'b0};
      end
      FMT_J: begin
        w_rs1 = '0;
        w_rs2 = '0;
        w_imm = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                 in_inst[20], in_inst[30:21], 1'b0};
      end
      default: begin
        w_rs1 = '0;
        w_rs2 = '0;
        w_rd  = '0;
        w_imm = '0;
      end
    endcase
  end

  assign w_is_ill = (w_fmt == FMT_ILL);
  assign in_ready = !r_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid   <= 1'b0;
      r_type    <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_rd      <= '0;
      r_func3   <= '0;
      r_imm     <= '0;
      r_illegal <= 1'b0;
      r_dec_cnt <= '0;
      r_ill_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_valid   <= 1'b1;
        r_type    <= w_fmt;
        r_rs1     <= w_rs1;
        r_rs2     <= w_rs2;
        r_rd      <= w_rd;
        r_func3   <= w_f3;
        r_imm     <= w_imm;
        r_illegal <= w_is_ill;
        if (w_is_ill) begin
          if (r_ill_cnt != '1) r_ill_cnt <= r_ill_cnt + 1'b1;
        end else begin
          r_dec_cnt <= r_dec_cnt + 1'b1;
        end
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid   = r_valid;
  assign out_type    = r_type;
  assign out_rs1     = r_rs1;
  assign out_rs2     = r_rs2;
  assign out_rd      = r_rd;
  assign out_func3   = r_func3;
  assign out_imm     = r_imm;
  assign out_illegal = r_illegal;
  assign dec_cnt     = r_dec_cnt;
  assign ill_cnt     = r_ill_cnt;

endmodule
